// File: rtl/alu.sv
// ALU with a one-cycle registered result and a registered zero flag.
//
// The opcode values live in package Definitions so that every block decoding
// the same OP bus shares one encoding.
//
// Optional feature, macro ALU_ROTATE_EN:
//   defined   -> ROL (12) and ROR (13) rotate A by B[$clog2(W)-1:0]
//   undefined -> ROL and ROR decode as unlisted opcodes (Out=0, Zero=1)
// The macro only adds the two rotate decodes. It does not change the ports,
// the latency or any other opcode.

package Definitions;
  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_AND   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_XOR   = 4;
  localparam int unsigned OP_NOT   = 5;
  localparam int unsigned OP_SHL   = 6;
  localparam int unsigned OP_SHR   = 7;
  localparam int unsigned OP_SRA   = 8;
  localparam int unsigned OP_CMP   = 9;
  localparam int unsigned OP_PASSA = 10;
  localparam int unsigned OP_PASSB = 11;
  localparam int unsigned OP_ROL   = 12;
  localparam int unsigned OP_ROR   = 13;
endpackage

module alu
  import Definitions::*;
#(
  parameter int W   = 8,
  parameter int Ops = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic [W-1:0]   Out,
  output logic           Zero
);

  // Width of the shift/rotate amount. This is held at one bit when W is 1 so
  // that the amount slice is never empty.
  localparam int SW = (W > 1) ? $clog2(W) : 1;

  // Only the low SW bits of B steer the shifters. Higher bits are ignored.
  logic [SW-1:0] amt;
  assign amt = InputB[SW-1:0];

  // One shared adder serves ADD, SUB and CMP. Subtraction is A + ~B + 1.
  // CMP uses the same difference, so Zero reports A == B for it.
  logic         sub_sel;
  logic [W-1:0] addsub_b;
  logic [W-1:0] addsub_res;

  // Select subtract mode for SUB and CMP.
  always_comb begin
    sub_sel = (OP == Ops'(OP_SUB)) || (OP == Ops'(OP_CMP));
  end

  assign addsub_b   = sub_sel ? ~InputB : InputB;
  assign addsub_res = InputA + addsub_b + W'(sub_sel);

  // Logarithmic barrel shifters. Stage gi moves the data by 2**gi positions
  // when amt[gi] is set. Element 0 of each chain is the raw operand.
  logic [W-1:0] shl_chain [SW+1];
  logic [W-1:0] shr_chain [SW+1];
  logic [W-1:0] sra_chain [SW+1];

  assign shl_chain[0] = InputA;
  assign shr_chain[0] = InputA;
  assign sra_chain[0] = InputA;

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_shift
      localparam int S = 1 << gi;
      assign shl_chain[gi+1] = amt[gi] ? (shl_chain[gi] << S) : shl_chain[gi];
      assign shr_chain[gi+1] = amt[gi] ? (shr_chain[gi] >> S) : shr_chain[gi];
      assign sra_chain[gi+1] = amt[gi] ? $unsigned($signed(sra_chain[gi]) >>> S)
                                       : sra_chain[gi];
    end
  endgenerate

`ifdef ALU_ROTATE_EN
  // Rotators built the same way as the shifters. Each stage rotates by less
  // than W positions. Stacked stages therefore give a rotation of amt mod W.
  logic [W-1:0] rol_chain [SW+1];
  logic [W-1:0] ror_chain [SW+1];

  assign rol_chain[0] = InputA;
  assign ror_chain[0] = InputA;

  generate
    for (gi = 0; gi < SW; gi++) begin : g_rotate
      localparam int S = 1 << gi;
      assign rol_chain[gi+1] = amt[gi]
                             ? ((rol_chain[gi] << S) | (rol_chain[gi] >> (W - S)))
                             : rol_chain[gi];
      assign ror_chain[gi+1] = amt[gi]
                             ? ((ror_chain[gi] >> S) | (ror_chain[gi] << (W - S)))
                             : ror_chain[gi];
    end
  endgenerate
`endif

  // Next result. Unlisted opcodes fall to the default and produce zero.
  logic [W-1:0] result_next;
  logic         zero_next;

  // Opcode decode and result selection.
  always_comb begin
    result_next = '0;
    case (OP)
      Ops'(OP_ADD):   result_next = addsub_res;
      Ops'(OP_SUB):   result_next = addsub_res;
      Ops'(OP_AND):   result_next = InputA & InputB;
      Ops'(OP_OR):    result_next = InputA | InputB;
      Ops'(OP_XOR):   result_next = InputA ^ InputB;
      Ops'(OP_NOT):   result_next = ~InputA;
      Ops'(OP_SHL):   result_next = shl_chain[SW];
      Ops'(OP_SHR):   result_next = shr_chain[SW];
      Ops'(OP_SRA):   result_next = sra_chain[SW];
      Ops'(OP_CMP):   result_next = addsub_res;
      Ops'(OP_PASSA): result_next = InputA;
      Ops'(OP_PASSB): result_next = InputB;
`ifdef ALU_ROTATE_EN
      Ops'(OP_ROL):   result_next = rol_chain[SW];
      Ops'(OP_ROR):   result_next = ror_chain[SW];
`endif
      default:        result_next = '0;
    endcase
  end

  // The flag is derived from the value about to be registered, so Out and
  // Zero always describe the same result.
  assign zero_next = (result_next == '0);

  // Result register. Reset clears Out and raises Zero at once, and it blocks
  // capture while it is held.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out  <= '0;
      Zero <= 1'b1;
    end else begin
      Out  <= result_next;
      Zero <= zero_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu (W=8, Ops=5). Each task applies hand-computed
// vectors and compares Out/Zero one rising edge later. The rotate checks
// follow whether ALU_ROTATE_EN is defined for the build.

module tb_alu;

  localparam int W   = 8;
  localparam int Ops = 5;

  logic           Clk;
  logic           Reset;
  logic [W-1:0]   InputA;
  logic [W-1:0]   InputB;
  logic [Ops-1:0] OP;
  logic [W-1:0]   Out;
  logic           Zero;

  int errors = 0;
  int checks = 0;

  alu #(.W(W), .Ops(Ops)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .InputA (InputA),
    .InputB (InputB),
    .OP     (OP),
    .Out    (Out),
    .Zero   (Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Applies one operation, then returns 1 time unit after the next rising edge.
  task automatic step(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    OP     = op;
    InputA = a;
    InputB = b;
    @(posedge Clk);
    #1;
    $display("op=%02h a=%02h b=%02h -> out=%02h zero=%0b", op, a, b, Out, Zero);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    OP = 5'd0; InputA = 8'h12; InputB = 8'h34;
    @(posedge Clk); #1;
    checks++;
    if (Out !== 8'h00 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold out=%02h zero=%0b expected out=00 zero=1", Out, Zero);
    end
    #3 Reset = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (Out !== 8'h46 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release out=%02h zero=%0b expected out=46 zero=0", Out, Zero);
    end
  endtask

  task automatic test_add_cmp;
    logic [4:0] ops [4]  = '{5'd0, 5'd0, 5'd9, 5'd9};
    logic [7:0] av  [4]  = '{8'hFF, 8'h12, 8'h01, 8'h05};
    logic [7:0] bv  [4]  = '{8'h01, 8'h34, 8'h01, 8'h03};
    logic [7:0] ev  [4]  = '{8'h00, 8'h46, 8'h00, 8'h02};
    logic       zv  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(ops[i], av[i], bv[i]);
      checks++;
      if (Out !== ev[i] || Zero !== zv[i]) begin
        errors++;
        $display("FAIL add_cmp[%0d] out=%02h zero=%0b expected out=%02h zero=%0b",
                 i, Out, Zero, ev[i], zv[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [4:0] ops [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10, 5'd11, 5'd11};
    logic [7:0] bv  [9] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00};
    logic [7:0] ev  [9] = '{8'h1D, 8'h69, 8'h42, 8'hDB, 8'h99, 8'h3C, 8'hC3, 8'h5A, 8'h00};
    for (int i = 0; i < 9; i++) begin
      step(ops[i], 8'hC3, bv[i]);
      checks++;
      if (Out !== ev[i] || Zero !== (ev[i] == 8'h00)) begin
        errors++;
        $display("FAIL logic op=%0d out=%02h zero=%0b expected out=%02h zero=%0b",
                 ops[i], Out, Zero, ev[i], (ev[i] == 8'h00));
      end
    end
  endtask

  task automatic test_shift;
    logic [4:0] ops [9] = '{5'd6, 5'd7, 5'd8, 5'd6, 5'd8, 5'd7, 5'd6, 5'd8, 5'd8};
    logic [7:0] av  [9] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h7F, 8'h81};
    logic [7:0] bv  [9] = '{8'h01, 8'h09, 8'h01, 8'h00, 8'h03, 8'h07, 8'hF7, 8'h02, 8'h10};
    logic [7:0] ev  [9] = '{8'h02, 8'h40, 8'hC0, 8'h81, 8'hF0, 8'h01, 8'h80, 8'h1F, 8'h81};
    for (int i = 0; i < 9; i++) begin
      step(ops[i], av[i], bv[i]);
      checks++;
      if (Out !== ev[i] || Zero !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d] out=%02h zero=%0b expected out=%02h zero=0",
                 i, Out, Zero, ev[i]);
      end
    end
  endtask

  task automatic test_unlisted_rotate;
    logic [4:0] ops [5] = '{5'h1F, 5'd14, 5'd12, 5'd13, 5'd12};
    logic [7:0] bv  [5] = '{8'h81, 8'h01, 8'h01, 8'h01, 8'h00};
`ifdef ALU_ROTATE_EN
    logic [7:0] ev  [5] = '{8'h00, 8'h00, 8'h03, 8'hC0, 8'h81};
`else
    logic [7:0] ev  [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 5; i++) begin
      step(ops[i], 8'h81, bv[i]);
      checks++;
      if (Out !== ev[i] || Zero !== (ev[i] == 8'h00)) begin
        errors++;
        $display("FAIL unlisted_rotate op=%02h out=%02h zero=%0b expected out=%02h zero=%0b",
                 ops[i], Out, Zero, ev[i], (ev[i] == 8'h00));
      end
    end
  endtask

  task automatic test_back_to_back;
    step(5'd0, 8'h12, 8'h34);
    // New inputs must not reach Out before the next edge.
    OP = 5'd11; InputB = 8'h77;
    #2;
    checks++;
    if (Out !== 8'h46 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL latency_hold out=%02h zero=%0b expected out=46 zero=0", Out, Zero);
    end
    @(posedge Clk); #1;
    checks++;
    if (Out !== 8'h77 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL latency_update out=%02h zero=%0b expected out=77 zero=0", Out, Zero);
    end
  endtask

  task automatic test_reset_mid;
    step(5'd10, 8'hA5, 8'h00);
    OP = 5'd11; InputB = 8'hFF;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Out !== 8'h00 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_async out=%02h zero=%0b expected out=00 zero=1", Out, Zero);
    end
    @(posedge Clk); #1;
    checks++;
    if (Out !== 8'h00 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold out=%02h zero=%0b expected out=00 zero=1", Out, Zero);
    end
    #3 Reset = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (Out !== 8'hFF || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release out=%02h zero=%0b expected out=FF zero=0", Out, Zero);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout out=%02h zero=%0b expected bench completion", Out, Zero);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_cmp();
    test_logic();
    test_shift();
    test_unlisted_rotate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
